// File: rtl/gray_pkg.sv
// Shared Gray-code helpers: binary <-> reflected-binary Gray conversion.
// Both functions work on 32-bit values; narrower counts are zero-extended
// on the way in and truncated on the way out, which leaves the result
// unchanged because the extra upper bits are all zero.
package gray_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  // Binary to Gray: each Gray bit is the XOR of a binary bit and its upper neighbour.
  function automatic logic [31:0] bin2gray(input logic [31:0] x);
    return x ^ (x >> 1);
  endfunction

  // Gray to binary: prefix XOR running from the MSB downwards.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b     = 32'd0;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_code_counter.sv
// Free-running W-bit up-counter with a Gray-coded primary output.
// Binary and Gray values are both held in flops so cnt comes straight from
// a register and changes in exactly one bit per increment, making it safe
// to sample from another clock domain. tc flags the step that wraps to 0.
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_bin,
  output logic         tc
);

  localparam logic [W-1:0] ONE_W      = W'(32'd1);
  localparam logic [W-1:0] ZERO_W     = {W{1'b0}};
  localparam logic [W-1:0] ALL_ONES_W = {W{1'b1}};

  logic [W-1:0] bin_r;
  logic [W-1:0] gray_r;
  logic [W-1:0] bin_next_s;
  logic [W-1:0] gray_next_s;
  logic         at_max_s;

  // Next binary value (natural mod 2^W wrap) and its Gray encoding.
  always_comb begin
    bin_next_s  = bin_r + ONE_W;
    gray_next_s = W'(bin2gray(32'(bin_next_s)));
  end

  // Count state: rst_n is an asynchronous, active-high clear with priority over ce.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      bin_r  <= ZERO_W;
      gray_r <= ZERO_W;
    end else if (ce) begin
      bin_r  <= bin_next_s;
      gray_r <= gray_next_s;
    end else begin
      bin_r  <= bin_r;
      gray_r <= gray_r;
    end
  end

  // Terminal count: the next enabled edge wraps the count back to zero.
  always_comb begin
    at_max_s = (bin_r == ALL_ONES_W);
    tc       = ce & at_max_s & ~rst_n;
  end

  assign cnt     = gray_r;
  assign cnt_bin = bin_r;

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed bench for gray_code_counter: W=4 main instance plus W=1 and W=8.
module tb_gray_code_counter;
  import gray_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce4, ce1, ce8;
  logic [3:0] cnt4, cnt_bin4;
  logic       tc4;
  logic [0:0] cnt1, cnt_bin1;
  logic       tc1;
  logic [7:0] cnt8, cnt_bin8;
  logic       tc8;

  int errors = 0;
  int checks = 0;

  // Hand-computed Gray code for binary 0..15.
  logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  logic [3:0] prev4;
  logic [7:0] prev8;
  logic [3:0] model;
  bit         seen [256];

  gray_code_counter #(.W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ce(ce4), .cnt(cnt4), .cnt_bin(cnt_bin4), .tc(tc4));
  gray_code_counter #(.W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ce(ce1), .cnt(cnt1), .cnt_bin(cnt_bin1), .tc(tc1));
  gray_code_counter #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ce(ce8), .cnt(cnt8), .cnt_bin(cnt_bin8), .tc(tc8));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge (one rising edge in between).
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    ce4   = 1'b1;
    ce1   = 1'b0;
    ce8   = 1'b0;

    // Reset held with ce=1: everything stays at zero.
    repeat (3) @(negedge clk);
    check_val("rst_cnt", 32'(cnt4), 32'h0);
    check_val("rst_bin", 32'(cnt_bin4), 32'h0);
    check_val("rst_tc", 32'(tc4), 32'h0);
    ce4 = 1'bx;
    #1;
    check_val("rst_x_cnt", 32'(cnt4), 32'h0);
    check_val("rst_x_bin", 32'(cnt_bin4), 32'h0);
    check_val("rst_x_tc", 32'(tc4), 32'h0);
    ce4 = 1'b1;
    repeat (7) @(negedge clk);
    check_val("rst_hold", 32'(cnt4), 32'h0);

    // Release and count a full period, checking wrap and tc.
    rst_n = 1'b0;
    ce1   = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      check_val("tc_pre", 32'(tc4), 32'(i == 15));
      if (i < 2) begin
        check_val("w1_cnt", 32'(cnt1), 32'(i));
        check_val("w1_tc", 32'(tc1), 32'(i));
      end
      step();
      if (i == 1) begin
        check_val("w1_wrap", 32'(cnt1), 32'h0);
        check_val("w1_wrap_bin", 32'(cnt_bin1), 32'h0);
        ce1 = 1'b0;
      end
      check_val("seq_cnt", 32'(cnt4), 32'(gtab[(i + 1) % 16]));
      check_val("seq_bin", 32'(cnt_bin4), 32'((i + 1) % 16));
    end

    // Enable gating at 0110.
    for (int k = 1; k <= 4; k++) begin
      step();
      check_val("to_0110", 32'(cnt4), 32'(gtab[k]));
    end
    ce4 = 1'b0;
    #1;
    check_val("hold_tc0", 32'(tc4), 32'h0);
    repeat (5) begin
      step();
      check_val("hold_cnt", 32'(cnt4), 32'h6);
      check_val("hold_tc", 32'(tc4), 32'h0);
    end
    ce4 = 1'b1;
    step();
    check_val("resume", 32'(cnt4), 32'h7);

    // Asynchronous reset between edges at 1101.
    for (int k = 6; k <= 9; k++) begin
      step();
      check_val("to_1101", 32'(cnt4), 32'(gtab[k]));
    end
    #2 rst_n = 1'b1;
    #1;
    check_val("async_cnt", 32'(cnt4), 32'h0);
    check_val("async_bin", 32'(cnt_bin4), 32'h0);
    check_val("async_tc", 32'(tc4), 32'h0);
    step();
    check_val("async_hold", 32'(cnt4), 32'h0);
    rst_n = 1'b0;
    step();
    check_val("restart_cnt", 32'(cnt4), 32'h1);
    check_val("restart_bin", 32'(cnt_bin4), 32'h1);

    // Long run with random enable.
    model = 4'd1;
    for (int n = 0; n < 1000; n++) begin
      ce4   = 1'($urandom_range(1, 0));
      prev4 = cnt4;
      #1;
      check_val("rnd_tc", 32'(tc4), 32'(ce4 && (model == 4'd15)));
      step();
      if (ce4) model = model + 4'd1;
      check_val("rnd_bin", 32'(cnt_bin4), 32'(model));
      check_val("rnd_cnt", 32'(cnt4), 32'(gtab[model]));
      check_val("rnd_g2b", gray2bin(32'(cnt4)), 32'(cnt_bin4));
      check_val("rnd_ham", 32'($countones(cnt4 ^ prev4)), 32'(ce4));
    end

    // W=8: one full period, each value once, back to zero.
    ce4 = 1'b0;
    for (int v = 0; v < 256; v++) seen[v] = 1'b0;
    check_val("w8_start", 32'(cnt8), 32'h0);
    seen[0] = 1'b1;
    ce8 = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      prev8 = cnt8;
      step();
      if (k < 256) begin
        check_val("w8_uniq", 32'(seen[cnt8]), 32'h0);
        seen[cnt8] = 1'b1;
      end
      check_val("w8_bin", 32'(cnt_bin8), 32'(k % 256));
      check_val("w8_g2b", gray2bin(32'(cnt8)), 32'(k % 256));
      check_val("w8_ham", 32'($countones(cnt8 ^ prev8)), 32'h1);
    end
    check_val("w8_wrap", 32'(cnt8), 32'h0);
    ce8 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
